// File: rtl/fetch_if.sv
// Fetch controller bus: datapath/decode handshakes plus the I-cache request channel.
// The master modport is the fetch controller; the slave modport is its surroundings.
interface fetch_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_next;
    logic            redirect_req;
    logic            wfi_req;
    logic            irq_pending;
    logic            id_ready;
    logic            icache_ack;
    logic [XLEN-1:0] icache_rdata;
    logic            icache_req;
    logic [XLEN-1:0] icache_addr;
    logic            if_stall;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [31:0]     stall_cnt;

    modport master (
        input  pc_next, redirect_req, wfi_req, irq_pending, id_ready,
        input  icache_ack, icache_rdata,
        output icache_req, icache_addr, if_stall, if_valid, if_instr, stall_cnt
    );

    modport slave (
        output pc_next, redirect_req, wfi_req, irq_pending, id_ready,
        output icache_ack, icache_rdata,
        input  icache_req, icache_addr, if_stall, if_valid, if_instr, stall_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding I-cache request, decode back-pressure,
// redirect/WFI handling and a saturating stall-cycle counter.
//
// state    | meaning
// RST_WAIT | first cycle after reset, no request, late acks ignored
// FETCH    | request outstanding at icache_addr
// HOLD     | response captured, waiting for decode to accept it
// DISCARD  | request abandoned, waiting for its ack to drain
// WFI      | asleep until irq_pending or redirect_req
module fetch_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);
    localparam logic [2:0] RST_WAIT = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] HOLD     = 3'd2;
    localparam logic [2:0] DISCARD  = 3'd3;
    localparam logic [2:0] WFI      = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            wfi_pend_q, wfi_pend_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic            valid, use_hold, stall;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hold_d     = hold_q;
        wfi_pend_d = wfi_pend_q;
        valid      = 1'b0;
        use_hold   = 1'b0;
        stall      = 1'b1;
        case (state_q)
            RST_WAIT: begin
                state_d = FETCH;
                if (bus.redirect_req) begin
                    stall  = 1'b0;
                    addr_d = bus.pc_next;
                end
            end
            FETCH: begin
                if (bus.redirect_req) begin
                    stall   = 1'b0;
                    addr_d  = bus.pc_next;
                    state_d = bus.icache_ack ? FETCH : DISCARD;
                end else if (bus.wfi_req) begin
                    if (bus.icache_ack) begin
                        state_d = WFI;
                    end else begin
                        wfi_pend_d = 1'b1;
                        state_d    = DISCARD;
                    end
                end else if (bus.icache_ack) begin
                    if (bus.id_ready) begin
                        valid  = 1'b1;
                        stall  = 1'b0;
                        addr_d = bus.pc_next;
                    end else begin
                        hold_d  = bus.icache_rdata;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_req) begin
                    stall   = 1'b0;
                    addr_d  = bus.pc_next;
                    state_d = FETCH;
                end else if (bus.wfi_req) begin
                    state_d = WFI;
                end else if (bus.id_ready) begin
                    valid    = 1'b1;
                    use_hold = 1'b1;
                    stall    = 1'b0;
                    addr_d   = bus.pc_next;
                    state_d  = FETCH;
                end
            end
            DISCARD: begin
                // The in-flight response still has to drain; redirects only retarget the next fetch.
                if (bus.redirect_req) begin
                    stall  = 1'b0;
                    addr_d = bus.pc_next;
                end else if (bus.wfi_req) begin
                    wfi_pend_d = 1'b1;
                end
                if (bus.icache_ack) begin
                    state_d = wfi_pend_d ? WFI : FETCH;
                end
            end
            WFI: begin
                if (bus.irq_pending || bus.redirect_req) begin
                    stall      = ~bus.redirect_req;
                    addr_d     = bus.pc_next;
                    wfi_pend_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: state_d = RST_WAIT;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall && !bus.redirect_req && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_WAIT;
            addr_q      <= RESET_PC;
            hold_q      <= '0;
            wfi_pend_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hold_q      <= hold_d;
            wfi_pend_q  <= wfi_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.icache_req  = (state_q == FETCH);
    assign bus.icache_addr = addr_q;
    assign bus.if_valid    = valid;
    assign bus.if_instr    = valid ? (use_hold ? hold_q : bus.icache_rdata) : NOP_INSTR;
    assign bus.if_stall    = stall;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: instructions expected at decode are queued when the
// I-cache response is driven and compared whenever if_valid is seen.
module tb_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] sb_q[$];

    fetch_if #(.XLEN(32)) bus ();

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic rd, input logic wf, input logic irq, input logic rdy,
                       input logic ack, input logic [31:0] rdata, input logic [31:0] pcn);
        bus.redirect_req = rd;
        bus.wfi_req      = wf;
        bus.irq_pending  = irq;
        bus.id_ready     = rdy;
        bus.icache_ack   = ack;
        bus.icache_rdata = rdata;
        bus.pc_next      = pcn;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // decode-side monitor
    always @(negedge clk) begin
        if (rst_n && bus.if_valid) begin
            if (sb_q.size() == 0) chk("sb_spurious_valid", bus.if_valid, 1'b0);
            else                  chk("sb_instr", bus.if_instr, sb_q.pop_front());
        end else begin
            chk("nop_when_invalid", bus.if_instr, NOP);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv(0, 0, 0, 1, 1, 32'hBAD0_0000, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", bus.icache_req, 0);
        chk("rst_addr", bus.icache_addr, 32'h0);
        chk("rst_valid", bus.if_valid, 0);
        chk("rst_stall", bus.if_stall, 1);
        chk("rst_cnt", bus.stall_cnt, 0);
        tick();
        rst_n = 1'b1;

        // RST_WAIT with a late ack still on the bus
        @(negedge clk);
        chk("rstwait_req", bus.icache_req, 0);
        chk("rstwait_stall", bus.if_stall, 1);
        chk("rstwait_valid", bus.if_valid, 0);
        tick();

        // back-to-back fetch
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 1, 1, 32'h1000_0000 + i, 32'(4 * i + 4));
            sb_q.push_back(32'h1000_0000 + i);
            @(negedge clk);
            chk("b2b_req", bus.icache_req, 1);
            chk("b2b_addr", bus.icache_addr, 32'(4 * i));
            chk("b2b_stall", bus.if_stall, 0);
            tick();
        end

        // decode back-pressure for three cycles
        drv(0, 0, 0, 0, 1, 32'h00A0_0093, 32'h10);
        sb_q.push_back(32'h00A0_0093);
        @(negedge clk);
        chk("bp_addr", bus.icache_addr, 32'hC);
        chk("bp_valid", bus.if_valid, 0);
        chk("bp_stall", bus.if_stall, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drv(0, 0, 0, 0, 0, 32'h0, 32'h10);
            @(negedge clk);
            chk("hold_req", bus.icache_req, 0);
            chk("hold_stall", bus.if_stall, 1);
            tick();
        end
        drv(0, 0, 0, 1, 0, 32'h0, 32'h10);
        @(negedge clk);
        chk("hold_release_valid", bus.if_valid, 1);
        chk("hold_release_stall", bus.if_stall, 0);
        chk("hold_cnt", bus.stall_cnt, 4);
        tick();

        // redirect with delayed ack
        drv(1, 0, 0, 1, 0, 32'h0, 32'h200);
        @(negedge clk);
        chk("redir_addr_before", bus.icache_addr, 32'h10);
        chk("redir_stall", bus.if_stall, 0);
        tick();
        drv(0, 0, 0, 1, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("discard_req", bus.icache_req, 0);
        chk("discard_addr", bus.icache_addr, 32'h200);
        tick();
        drv(0, 0, 0, 1, 1, 32'hBAD0_0001, 32'h0);
        @(negedge clk);
        chk("discard_drop", bus.if_valid, 0);
        tick();
        drv(0, 0, 0, 1, 1, 32'h2000_0000, 32'h204);
        sb_q.push_back(32'h2000_0000);
        @(negedge clk);
        chk("refetch_req", bus.icache_req, 1);
        chk("refetch_addr", bus.icache_addr, 32'h200);
        tick();

        // redirect coincident with ack
        drv(1, 0, 0, 1, 1, 32'hBAD0_0002, 32'h200);
        @(negedge clk);
        chk("redir_ack_addr", bus.icache_addr, 32'h204);
        chk("redir_ack_valid", bus.if_valid, 0);
        chk("redir_ack_stall", bus.if_stall, 0);
        tick();
        drv(0, 0, 0, 1, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("no_discard_req", bus.icache_req, 1);
        chk("no_discard_addr", bus.icache_addr, 32'h200);
        tick();

        // WFI with outstanding request, then wake
        drv(0, 1, 0, 1, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wfi_req_stall", bus.if_stall, 1);
        tick();
        drv(0, 0, 0, 1, 1, 32'hBAD0_0003, 32'h0);
        @(negedge clk);
        chk("wfi_discard_req", bus.icache_req, 0);
        chk("wfi_discard_drop", bus.if_valid, 0);
        tick();
        drv(0, 0, 0, 1, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wfi_sleep_req", bus.icache_req, 0);
        chk("wfi_sleep_stall", bus.if_stall, 1);
        tick();
        drv(0, 0, 1, 1, 0, 32'h0, 32'h80);
        @(negedge clk);
        chk("wfi_wake_req", bus.icache_req, 0);
        tick();
        drv(0, 0, 0, 1, 1, 32'h3000_0000, 32'h84);
        sb_q.push_back(32'h3000_0000);
        @(negedge clk);
        chk("wake_req", bus.icache_req, 1);
        chk("wake_addr", bus.icache_addr, 32'h80);
        chk("wake_cnt", bus.stall_cnt, 11);
        tick();

        // asynchronous reset with a request pending
        drv(0, 0, 0, 1, 0, 32'h0, 32'h88);
        @(negedge clk);
        chk("pre_rst_req", bus.icache_req, 1);
        chk("pre_rst_addr", bus.icache_addr, 32'h84);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", bus.icache_req, 0);
        chk("async_rst_addr", bus.icache_addr, 32'h0);
        chk("async_rst_valid", bus.if_valid, 0);
        chk("async_rst_instr", bus.if_instr, NOP);
        chk("async_rst_stall", bus.if_stall, 1);
        chk("async_rst_cnt", bus.stall_cnt, 0);
        drv(0, 0, 0, 1, 1, 32'hBAD0_0004, 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("late_ack_valid", bus.if_valid, 0);
        chk("late_ack_req", bus.icache_req, 0);
        tick();
        drv(0, 0, 0, 1, 0, 32'h0, 32'h4);
        @(negedge clk);
        chk("post_rst_req", bus.icache_req, 1);
        chk("post_rst_addr", bus.icache_addr, 32'h0);
        chk("post_rst_cnt", bus.stall_cnt, 1);
        tick();

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL take parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL take parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL take parameter NOP_INSTR, default 32'h0000_0013, instruction emitted when not valid.
REQ-004 SHALL have ports, one per line:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_next  in  XLEN  next PC from fetch datapath.
- redirect_req  in  1  CSR/exe new-PC request.
- wfi_req  in  1  enter wait-for-interrupt.
- irq_pending  in  1  wake from WFI.
- id_ready  in  1  decode accepts instruction this cycle.
- icache_ack  in  1  one-cycle response strobe.
- icache_rdata  in  XLEN  response data, valid with ack.
- icache_req  out  1  request, level, held until ack.
- icache_addr  out  XLEN  request address, registered.
- if_stall  out  1  datapath holds pc_ff.
- if_valid  out  1  if_instr valid to decode.
- if_instr  out  XLEN  instruction to decode.
- stall_cnt  out  32  saturating stall-cycle counter.

Function
REQ-005 SHALL implement states RST_WAIT, FETCH, HOLD, DISCARD, WFI (one-hot or binary, one active).
REQ-006 RST_WAIT: icache_req=0, if_stall=1; next cycle -> FETCH unconditionally.
REQ-007 FETCH: icache_req=1; icache_addr stable while req high and ack low.
REQ-008 FETCH, ack & id_ready, no redirect/wfi: if_valid=1, if_instr=icache_rdata, if_stall=0, icache_addr<=pc_next, stay FETCH (back-to-back, 1 instr/cycle).
REQ-009 FETCH, ack & ~id_ready: capture rdata into hold register, if_valid=0, if_stall=1 -> HOLD.
REQ-010 FETCH, no ack: if_stall=1, if_valid=0.
REQ-011 HOLD: icache_req=0, if_valid=id_ready, if_instr=hold register; on id_ready: if_stall=0, icache_addr<=pc_next -> FETCH; else stay.
REQ-012 Priority per cycle: redirect_req > wfi_req > ack/id_ready handling.
REQ-013 redirect_req in FETCH with ack same cycle: drop data (if_valid=0), icache_addr<=pc_next -> FETCH.
REQ-014 redirect_req in FETCH without ack: icache_addr<=pc_next, icache_req=0 next cycle -> DISCARD.
REQ-015 redirect_req in HOLD: drop held data, icache_addr<=pc_next -> FETCH.
REQ-016 DISCARD: icache_req=0, if_valid=0, if_stall=1; on icache_ack drop data -> FETCH (or WFI if wfi_pending); further redirect_req in DISCARD updates icache_addr<=pc_next only.
REQ-017 wfi_req in FETCH with ack or in HOLD: drop data -> WFI; in FETCH without ack: set wfi_pending -> DISCARD.
REQ-018 WFI: icache_req=0, if_valid=0, if_stall=1; irq_pending or redirect_req: icache_addr<=pc_next, clear wfi_pending -> FETCH.
REQ-019 if_instr SHALL equal NOP_INSTR whenever if_valid=0.
REQ-020 redirect_req cycle SHALL drive if_stall=0 so datapath loads new PC.
REQ-021 stall_cnt SHALL increment each cycle if_stall=1 and redirect_req=0, saturating at 32'hFFFF_FFFF.
REQ-022 At most one icache request SHALL be outstanding; no new req while in DISCARD.

Reset
REQ-023 On rst_n low, asynchronously: state=RST_WAIT, icache_req=0, icache_addr=RESET_PC, if_valid=0, if_instr=NOP_INSTR, if_stall=1, hold register=0, wfi_pending=0, stall_cnt=0.
REQ-024 Reset mid-request SHALL abandon the outstanding request; a late ack after reset while in RST_WAIT SHALL be ignored.

Verification
REQ-025 Reset release, ack every cycle, id_ready=1 -> icache_addr 0x0,0x4,0x8 on consecutive FETCH cycles; if_valid=1 from third cycle.
REQ-026 ack with id_ready=0 for 3 cycles, rdata=0x00A00093 -> HOLD, if_stall=1, if_instr emitted once when id_ready rises, stall_cnt+=3.
REQ-027 redirect_req, pc_next=0x200, ack delayed 2 cycles -> DISCARD, ack data dropped, next req at 0x200.
REQ-028 redirect_req coincident with ack -> if_valid=0, next icache_addr=0x200, no DISCARD.
REQ-029 wfi_req with outstanding req -> DISCARD, then WFI; irq_pending, pc_next=0x80 -> FETCH at 0x80.
REQ-030 rst_n low during FETCH with req pending -> all outputs at REQ-023 values immediately; stall_cnt=0.
